// File: rtl/fetch_decode_fsm.sv
// fetch_decode_fsm: fetches 16-bit instructions, retires jumps/NOPs/HALT locally
// and hands opcodes 0..8 to an external ALU controller via a start/done handshake.
module fetch_decode_fsm #(
  parameter int PC_W = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic [PC_W-1:0] memAddr,
  output logic            memRd,
  input  logic            memRdy,
  input  logic [15:0]     memData,
  output logic [3:0]      opCode,
  output logic [3:0]      ri,
  output logic [3:0]      rj,
  output logic [3:0]      imm,
  output logic            ALUstr,
  input  logic            IF,
  output logic            busy,
  output logic            halted,
  output logic [15:0]     retired
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, DISPATCH, WAIT_ALU, HALT} state_t;
  state_t state, stateNext;
  logic [PC_W-1:0] pc, pcNext;
  logic [15:0] ir, irNext;
  logic retire;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      ir <= '0;
      retired <= '0;
    end else begin
      state <= stateNext;
      pc <= pcNext;
      ir <= irNext;
      retired <= (retire && retired != 16'hFFFF) ? retired + 16'd1 : retired;
    end

  always_comb begin
    stateNext = state;
    pcNext = pc;
    irNext = ir;
    retire = 1'b0;
    case (state)
      IDLE: stateNext = run ? FETCH : IDLE;
      FETCH: begin
        irNext = memRdy ? memData : ir;
        stateNext = memRdy ? DECODE : FETCH;
      end
      DECODE: begin
        retire = ir[15:12] > 4'd8;
        stateNext = ir[15:12] <= 4'd8 ? DISPATCH : ir[15:12] == 4'hF ? HALT : FETCH;
        // HALT keeps the PC pointing at the halt instruction itself
        pcNext = ir[15:12] <= 4'd8 || ir[15:12] == 4'hF ? pc :
                 ir[15:12] == 4'd9 ? PC_W'(ir[7:0]) : pc + PC_W'(1);
      end
      DISPATCH: stateNext = WAIT_ALU;
      WAIT_ALU: begin
        retire = IF;
        pcNext = IF ? pc + PC_W'(1) : pc;
        stateNext = IF ? FETCH : WAIT_ALU;
      end
      HALT: stateNext = HALT;
      default: stateNext = IDLE;
    endcase
  end

  assign memAddr = pc;
  assign memRd = state == FETCH;
  assign ALUstr = state == DISPATCH;
  assign busy = state != IDLE && state != HALT;
  assign halted = state == HALT;
  assign {opCode, ri, rj, imm} = ir;
endmodule

// File: tb/tb_fetch_decode_fsm.sv
// tb_fetch_decode_fsm: instruction-level model of the sequencer checked against the DUT every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_fetch_decode_fsm;
  logic clk = 1'b0;
  logic reset, run, memRdy, IF, memRd, ALUstr, busy, halted;
  logic [7:0] memAddr;
  logic [15:0] memData, retired;
  logic [3:0] opCode, ri, rj, imm;
  logic [15:0] mem [256];
  int nPass = 0, nTotal = 0;
  logic [7:0] ePc;
  logic [15:0] eIr, eRet;
  logic eMemRd, eAlu, eBusy, eHalt;

  fetch_decode_fsm #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .run(run), .memAddr(memAddr), .memRd(memRd),
    .memRdy(memRdy), .memData(memData), .opCode(opCode), .ri(ri), .rj(rj),
    .imm(imm), .ALUstr(ALUstr), .IF(IF), .busy(busy), .halted(halted),
    .retired(retired)
  );

  assign memData = mem[memAddr];
  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic setOut(logic rd, logic al, logic bz, logic ht);
    eMemRd = rd;
    eAlu = al;
    eBusy = bz;
    eHalt = ht;
  endtask

  task automatic step(output bit ab);
    @(posedge clk or negedge reset);
    ab = !reset;
  endtask

  function automatic logic [15:0] bump(logic [15:0] r);
    return r == 16'hFFFF ? r : r + 16'd1;
  endfunction

  // Model: walks each instruction as a program; a reset anywhere restarts it from the top.
  initial begin : model
    bit ab;
    logic [3:0] op;
    forever begin
      ePc = 8'h00;
      eIr = '0;
      eRet = '0;
      setOut(0, 0, 0, 0);
      wait (reset === 1'b1);
      do step(ab); while (!ab && run !== 1'b1);
      while (!ab) begin
        setOut(1, 0, 1, 0);
        do step(ab); while (!ab && memRdy !== 1'b1);
        if (ab) break;
        eIr = mem[ePc];
        setOut(0, 0, 1, 0);
        step(ab);
        if (ab) break;
        op = eIr[15:12];
        if (op == 4'hF) begin
          eRet = bump(eRet);
          setOut(0, 0, 0, 1);
          do step(ab); while (!ab);
        end else if (op >= 4'd9) begin
          ePc = op == 4'd9 ? eIr[7:0] : ePc + 8'd1;
          eRet = bump(eRet);
        end else begin
          setOut(0, 1, 1, 0);
          step(ab);
          if (ab) break;
          setOut(0, 0, 1, 0);
          do step(ab); while (!ab && IF !== 1'b1);
          if (ab) break;
          ePc = ePc + 8'd1;
          eRet = bump(eRet);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    chk("cycle", {memAddr, memRd, ALUstr, busy, halted, retired, opCode, ri, rj, imm},
        {ePc, eMemRd, eAlu, eBusy, eHalt, eRet, eIr});
  endtask

  task automatic waitFor(int what, int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if ((what == 0 && ALUstr === 1'b1) || (what == 1 && halted === 1'b1)) return;
    end
    nTotal++;
    $display("FAIL wait%0d: condition not reached within %0d cycles", what, budget);
  endtask

  initial begin
    reset = 1'b0;
    run = 1'b0;
    memRdy = 1'b0;
    IF = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0123;
    mem[1] = 16'h1456;
    mem[2] = 16'h9005;
    mem[5] = 16'h90FF;
    mem[255] = 16'h2789;
    #2 chk("rstOut", {memAddr, memRd, ALUstr, busy, halted, retired, opCode}, 64'h0);
    tick();
    reset = 1'b1;
    run = 1'b1;
    memRdy = 1'b1;
    tick();
    chk("fetchRd", {memRd, busy, memAddr}, {1'b1, 1'b1, 8'h00});
    tick();
    chk("decFields", {busy, memRd, opCode, ri, rj, imm}, {1'b1, 1'b0, 16'h0123});
    run = 1'b0;
    memRdy = 1'b0;
    tick();
    chk("aluStr", {ALUstr, opCode, ri, rj, imm}, {1'b1, 16'h0123});
    tick();
    chk("aluStrOff", {ALUstr, memRd, busy}, 3'b001);
    repeat (5) tick();
    IF = 1'b1;
    tick();
    chk("pcInc", {memAddr, retired, memRd}, {8'd1, 16'd1, 1'b1});
    repeat (2) tick();
    IF = 1'b0;
    chk("strayIf", {memAddr, retired, opCode, memRd}, {8'd1, 16'd1, 4'h0, 1'b1});
    memRdy = 1'b1;
    tick();
    chk("lateFetch", {memRd, opCode, ri, rj, imm}, {1'b0, 16'h1456});
    waitFor(0, 10);
    IF = 1'b1;
    tick();
    tick();
    IF = 1'b0;
    chk("pc2", {memAddr, retired}, {8'd2, 16'd2});
    waitFor(0, 20);
    chk("jmpPc", {memAddr, retired, opCode}, {8'hFF, 16'd4, 4'h2});
    IF = 1'b1;
    tick();
    tick();
    IF = 1'b0;
    chk("wrap", {memAddr, retired, memRd}, {8'h00, 16'd5, 1'b1});
    waitFor(0, 10);
    tick();
    chk("inWait", {busy, ALUstr, memRd}, 3'b100);
    #2 reset = 1'b0;
    #1 chk("asyncRst", {memAddr, memRd, ALUstr, busy, halted, retired, opCode, ri, rj, imm}, 64'h0);
    tick();
    reset = 1'b1;
    IF = 1'b1;
    tick();
    tick();
    IF = 1'b0;
    chk("ifIgnored", {memAddr, busy, retired}, 25'h0);
    mem[0] = 16'hA000;
    mem[1] = 16'hF000;
    run = 1'b1;
    waitFor(1, 20);
    run = 1'b0;
    chk("halt", {memAddr, halted, busy, retired}, {8'd1, 1'b1, 1'b0, 16'd2});
    repeat (3) begin
      run = 1'b1;
      tick();
      run = 1'b0;
      tick();
    end
    chk("haltSticky", {memAddr, halted, busy, retired, memRd}, {8'd1, 1'b1, 1'b0, 16'd2, 1'b0});
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end
endmodule

// File: doc/fetch_decode_fsm.md
FETCH_DECODE_FSM -- requirements
Module: fetch_decode_fsm

Interface
REQ-001 Parameter: PC_W, 8, program-counter and memory-address width.
REQ-002 Parameter: RESET_PC, 0, PC value loaded on reset.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-low reset (reset=0 resets immediately, independent of clk).
REQ-005 Port: run  in  1  start request; sampled only in IDLE.
REQ-006 Port: memAddr  out  PC_W  instruction address, equals PC.
REQ-007 Port: memRd  out  1  instruction read request.
REQ-008 Port: memRdy  in  1  memory has valid data on memData this cycle.
REQ-009 Port: memData  in  16  instruction word: [15:12] opcode, [11:8] ri, [7:4] rj, [3:0] imm4; [7:0] imm8 for JMP.
REQ-010 Port: opCode  out  4  registered IR[15:12], feeds the ALU controller.
REQ-011 Port: ri, rj, imm  out  4 each  registered IR[11:8], IR[7:4], IR[3:0].
REQ-012 Port: ALUstr  out  1  one-cycle start pulse to the ALU controller.
REQ-013 Port: IF  in  1  ALU-controller done flag; instruction complete when sampled high.
REQ-014 Port: busy  out  1  high in any state except IDLE and HALT.
REQ-015 Port: halted  out  1  high in HALT.
REQ-016 Port: retired  out  16  count of completed instructions, saturating.

Function
REQ-017 States: IDLE, FETCH, DECODE, DISPATCH, WAIT_ALU, HALT; state register and IR updated only on clk edge or reset.
REQ-018 IDLE: memRd=0, ALUstr=0; run=1 at edge -> FETCH, else stay.
REQ-019 FETCH: memRd=1, memAddr=PC; memRdy=1 at edge -> IR<=memData, -> DECODE; memRdy=0 -> stay, memRd held high indefinitely (no timeout).
REQ-020 DECODE (exactly 1 cycle, memRd=0): opcode 0..8 -> DISPATCH; 9 (JMP) -> PC<=IR[7:0] (zero-extended/truncated to PC_W), retired+1, -> FETCH; 10..14 (NOP) -> PC<=PC+1, retired+1, -> FETCH; 15 (HALT) -> retired+1, -> HALT.
REQ-021 DISPATCH (exactly 1 cycle): ALUstr=1 -> WAIT_ALU; ALUstr is 0 in every other state.
REQ-022 WAIT_ALU: ALUstr=0, memRd=0; IF=1 at edge -> PC<=PC+1, retired+1, -> FETCH; IF=0 -> stay indefinitely.
REQ-023 IF high in any state other than WAIT_ALU is ignored.
REQ-024 HALT: sticky; only reset exits; run ignored; PC frozen at HALT address.
REQ-025 opCode/ri/rj/imm change only on IR load and remain stable from DECODE through WAIT_ALU.
REQ-026 PC arithmetic modulo 2^PC_W: PC=2^PC_W-1 increments to 0.
REQ-027 retired saturates at 16'hFFFF; no wrap.
REQ-028 memRdy high outside FETCH is ignored; IR unchanged.

Reset
REQ-029 reset=0: state=IDLE, PC=RESET_PC, IR=0, opCode/ri/rj/imm=0, memRd=0, ALUstr=0, busy=0, halted=0, retired=0, asynchronously.
REQ-030 Reset mid-operation (FETCH or WAIT_ALU) abandons the instruction; pending IF or memRdy after release ignored until the matching state is reached again.
REQ-031 First state transition possible on the first rising clk edge after reset returns to 1.

Verification
REQ-032 Reset release, run=1, mem[0]=16'h0123, memRdy same cycle -> DECODE next, ALUstr pulse 1 cycle with opCode=0, ri=1, rj=2, imm=3.
REQ-033 memRdy delayed 3 cycles in FETCH -> memRd held high 4 cycles, memAddr constant, IR unchanged until the memRdy cycle.
REQ-034 ALU op, IF returned 7 cycles after ALUstr -> PC 0->1, retired 0->1, memRd reasserted next cycle; stray IF in FETCH has no effect.
REQ-035 mem[5]=16'h90FF with PC_W=8 -> PC=255; next ALU op at 255 completes -> PC wraps to 0.
REQ-036 mem[0]=16'hA000, mem[1]=16'hF000 -> PC=1, HALT, halted=1, busy=0, retired=2; run pulses ignored.
REQ-037 reset=0 asserted mid-WAIT_ALU without clk edge -> outputs at reset values immediately; IF pulse after release produces no PC change.
